fir_mac_engine: RTL
===================

FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; parameters and ports are listed below.
REQ-002 Parameter TAPS, default 8, number of filter taps (power of two, 2..16).
REQ-003 Parameter N, default 16, sample/coefficient width (sign-magnitude: bit N-1 sign, N-2:0 magnitude).
REQ-004 Parameter ACC_W, default N+$clog2(TAPS)+1, signed two's-complement accumulator width.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  input sample present; in_data  in  N  sample; in_ready  out  1  sample accepted when in_valid&&in_ready.
REQ-008 coef_we  in  1  coefficient write strobe; coef_addr  in  $clog2(TAPS)  tap index; coef_data  in  N  coefficient.
REQ-009 out_valid  out  1  filtered sample present; out_data  out  N  result (sign-magnitude); out_ready  in  1  consumer accepts.

Function
REQ-010 FSM states IDLE, MAC, OUT; in_ready SHALL be 1 only in IDLE.
REQ-011 IDLE: on in_valid&&in_ready, delay line shifts (x[k]<=x[k-1], x[0]<=in_data), acc<=0, tap counter<=0, next state MAC.
REQ-012 MAC: one tap per cycle for TAPS cycles, k=0..TAPS-1; p_k = multiplier(x[k], h[k]); acc <= acc + sext(sm2tc(p_k)); after k=TAPS-1, next state OUT.
REQ-013 Product rule: p = {a[N-1]^b[N-1], (a[N-2:0]*b[N-2:0])[N-2:0]}, i.e. magnitude truncated modulo 2^(N-1).
REQ-014 sm2tc: magnitude 0 maps to 0 regardless of sign (0x8000 == 0); negative sign negates magnitude.
REQ-015 OUT: out_data = tc2sm(sat(acc)); sat clamps to [-(2^(N-1)-1), 2^(N-1)-1]; zero result SHALL be 0x0000, never 0x8000.
REQ-016 Latency: sample accepted in cycle t SHALL produce out_valid=1 in cycle t+TAPS+1.
REQ-017 out_valid and out_data SHALL be registered and held stable while out_ready=0; on out_valid&&out_ready, out_valid<=0 and state<=IDLE next cycle.
REQ-018 Throughput: at most one sample per TAPS+2 cycles; back-to-back accept allowed in the cycle after output handshake.
REQ-019 coef_we SHALL write h[coef_addr] only in IDLE; writes in MAC/OUT are dropped silently.
REQ-020 coef_we and accepted in_valid in the same IDLE cycle: both take effect; that sample uses the new coefficient.
REQ-021 acc SHALL never overflow: ACC_W bounds TAPS*(2^(N-1)-1).

Reset
REQ-022 rst SHALL force state IDLE, delay line 0, all coefficients 0, acc 0, tap counter 0, out_valid 0, out_data 0.
REQ-023 rst during MAC or OUT SHALL abort the computation; no out_valid for that sample.
REQ-024 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-025 Package eq_pkg SHALL hold N, default TAPS, ACC_W derivation, state enum type, and sm2tc/tc2sm/sat functions.
REQ-026 Product SHALL come from one instance of the team's existing multiplier module; no other sub-module.

Verification
REQ-027 h0=0x0002, others 0; in 0x0003 at t -> out_valid at t+9, out_data=0x0006.
REQ-028 h0=0x8002; in 0x0003 -> out_data=0x8006; h0=0x0080, in 0x0100 -> out_data=0x0000 (truncation wrap).
REQ-029 h0=0x0001, h1=0x8001; inputs 0x0005 then 0x0005 -> second out_data=0x0000 (not 0x8000).
REQ-030 All h=0x00FF; eight inputs 0x00FF -> eighth out_data=0x7FFF (sum 258056 saturated).
REQ-031 out_ready low 5 cycles in OUT -> out_data/out_valid stable, in_ready=0, coef_we ignored (readback via later output unchanged).
REQ-032 rst asserted at MAC cycle 3 -> no out_valid, in_ready=1 after release, next sample output equals zero-history result.

Source files
------------

// File: rtl/fir_mac_engine_pkg.sv
// Shared types and sign-magnitude / two's-complement helpers for the FIR MAC engine.
package eq_pkg;
  localparam int N        = 16;
  localparam int TAPS_DEF = 8;
  localparam int WIDE     = 32;
  localparam int SM_MAX   = (1 << (N-1)) - 1;

  function automatic int acc_width(input int taps, input int n);
    return n + $clog2(taps) + 1;
  endfunction

  localparam int ACC_W = acc_width(TAPS_DEF, N);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  // Negating a zero magnitude yields zero, so 0x8000 folds to 0.
  function automatic logic signed [N-1:0] sm2tc(input logic [N-1:0] sm);
    logic signed [N-1:0] mag;
    mag = {1'b0, sm[N-2:0]};
    return sm[N-1] ? -mag : mag;
  endfunction

  function automatic logic signed [N-1:0] sat(input logic signed [WIDE-1:0] a);
    logic signed [WIDE-1:0] lim;
    logic signed [WIDE-1:0] nlim;
    lim  = SM_MAX;
    nlim = -lim;
    if (a > lim)  return lim[N-1:0];
    if (a < nlim) return nlim[N-1:0];
    return a[N-1:0];
  endfunction

  function automatic logic [N-1:0] tc2sm(input logic signed [N-1:0] v);
    logic [N-1:0] neg;
    neg = -v;
    return (v < 0) ? {1'b1, neg[N-2:0]} : {1'b0, v[N-2:0]};
  endfunction
endpackage

// File: rtl/fir_mac_engine_mult.sv
// Sign-magnitude multiplier: sign is XOR, magnitude product truncated to N-1 bits.
module fir_mac_engine_mult #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] p_o
);
  assign p_o[N-1]   = a_i[N-1] ^ b_i[N-1];
  assign p_o[N-2:0] = a_i[N-2:0] * b_i[N-2:0];
endmodule

// File: rtl/fir_mac_engine.sv
// Sequential FIR filter: one multiply-accumulate per cycle over TAPS taps, then
// a held sign-magnitude result until the consumer takes it.
module fir_mac_engine import eq_pkg::*; #(
  parameter int TAPS  = TAPS_DEF,
  parameter int N     = eq_pkg::N,
  parameter int ACC_W = N + $clog2(TAPS) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [N-1:0]            in_data,
  output logic                    in_ready,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [N-1:0]            coef_data,
  output logic                    out_valid,
  output logic [N-1:0]            out_data,
  input  logic                    out_ready
);
  localparam int KW = $clog2(TAPS);

  state_e                  state_q;
  logic [KW-1:0]           k_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [TAPS-1:0][N-1:0]  x_q;
  logic [TAPS-1:0][N-1:0]  h_q;
  logic                    out_valid_q;
  logic [N-1:0]            out_data_q;

  logic [N-1:0]            prod;
  logic signed [N-1:0]     prod_tc;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [WIDE-1:0]  acc_wide;

  fir_mac_engine_mult #(.N(N)) u_mult (
    .a_i (x_q[k_q]),
    .b_i (h_q[k_q]),
    .p_o (prod)
  );

  assign prod_tc  = sm2tc(prod);
  assign acc_d    = acc_q + {{(ACC_W-N){prod_tc[N-1]}}, prod_tc};
  assign acc_wide = {{(WIDE-ACC_W){acc_d[ACC_W-1]}}, acc_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      h_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (coef_we) h_q[coef_addr] <= coef_data;
          if (in_valid) begin
            x_q     <= {x_q[TAPS-2:0], in_data};
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          k_q   <= k_q + 1'b1;
          // Result is registered on the last tap so out_valid lands at t+TAPS+1.
          if (k_q == KW'(TAPS-1)) begin
            out_valid_q <= 1'b1;
            out_data_q  <= tc2sm(sat(acc_wide));
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule
